// File: rtl/sigmoid_sweep_collector_pkg.sv
// Shared widths, state encoding and transistor-count helpers for the
// sigmoid sweep collector slice.
package sigmoid_sweep_collector_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 16;
  localparam int CNT_W = 9;
  localparam int CHK_W = 24;
  localparam int NUM_W = 51;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Transistor cost per bit of the basic cells used in this slice.
  localparam logic [NUM_W-1:0] FD2_BIT_NUM = 51'd28;
  localparam logic [NUM_W-1:0] ADD_BIT_NUM = 51'd28;
  localparam logic [NUM_W-1:0] CMP_BIT_NUM = 51'd12;
  localparam logic [NUM_W-1:0] MUX_BIT_NUM = 51'd12;

  // Transistor count of a bw-bit FD2 register bank.
  function automatic logic [NUM_W-1:0] reg_number(input int bw);
    return NUM_W'(bw) * FD2_BIT_NUM;
  endfunction

endpackage

// File: rtl/sigmoid_sweep_collector_fd2.sv
// BW-bit FD2 register wrapper: D flip-flops with asynchronous active-low clear.
module sigmoid_sweep_collector_fd2
  import sigmoid_sweep_collector_pkg::*;
#(
  parameter int BW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BW-1:0]    d,
  output logic [BW-1:0]    q,
  output logic [NUM_W-1:0] number
);

  // Plain storage; all enable/clear behaviour lives in the caller's d path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

  assign number = reg_number(BW);

endmodule

// File: rtl/sigmoid_sweep_collector_y_accum.sv
// Result accumulator: running checksum and unsigned maximum of accepted y values.
module sigmoid_sweep_collector_y_accum
  import sigmoid_sweep_collector_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             accept,
  input  logic [Y_W-1:0]   y,
  output logic [CHK_W-1:0] checksum,
  output logic [Y_W-1:0]   max_y,
  output logic [NUM_W-1:0] number
);

  logic [CHK_W-1:0] chk_d;
  logic [Y_W-1:0]   max_d;
  logic [NUM_W-1:0] chk_num;
  logic [NUM_W-1:0] max_num;

  // Next-value logic: clear wins over accept, otherwise hold.
  always_comb begin
    chk_d = checksum;
    max_d = max_y;
    if (clear) begin
      chk_d = '0;
      max_d = '0;
    end else if (accept) begin
      chk_d = checksum + {{(CHK_W-Y_W){1'b0}}, y};
      if (y > max_y) max_d = y;
    end
  end

  sigmoid_sweep_collector_fd2 #(.BW(CHK_W)) u_chk_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (chk_d),
    .q      (checksum),
    .number (chk_num)
  );

  sigmoid_sweep_collector_fd2 #(.BW(Y_W)) u_max_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (max_d),
    .q      (max_y),
    .number (max_num)
  );

  assign number = chk_num + max_num
                + NUM_W'(CHK_W) * (ADD_BIT_NUM + MUX_BIT_NUM)
                + NUM_W'(Y_W)   * (CMP_BIT_NUM + MUX_BIT_NUM);

endmodule

// File: rtl/sigmoid_sweep_collector.sv
// Self-test controller for the sigmoid unit: issues an x sweep, collects y
// results, tracks outstanding samples and flags protocol errors.
module sigmoid_sweep_collector
  import sigmoid_sweep_collector_pkg::*;
#(
  parameter logic [X_W-1:0] X_START = 8'h80,
  parameter int             TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_count,
  output logic [X_W-1:0]   o_x,
  output logic             o_in_valid,
  input  logic [Y_W-1:0]   i_y,
  input  logic             i_out_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [CHK_W-1:0] o_checksum,
  output logic [Y_W-1:0]   o_max_y,
  output logic             o_error,
  output logic [NUM_W-1:0] number
);

  localparam logic [8:0] TIMEOUT_L = 9'(TIMEOUT);
  // state(2) + four counters + timeout(8) + o_x(8) + four single-bit outputs
  localparam int TOP_FLOPS = 2 + 4*CNT_W + 8 + X_W + 4;

  state_t           state;
  logic [CNT_W-1:0] n_latched;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] result_cnt;
  logic [CNT_W-1:0] outstanding;
  logic [7:0]       timeout_cnt;

  logic             in_run;
  logic             issuing;
  logic             start_ok;
  logic             accept;
  logic             stray;
  logic [CNT_W-1:0] issue_next;
  logic [CNT_W-1:0] result_next;
  logic [CNT_W-1:0] outstanding_next;
  logic [8:0]       timeout_next;
  logic [NUM_W-1:0] acc_number;

  assign in_run      = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign issuing     = (state == ST_ISSUE);
  assign start_ok    = i_start && ((state == ST_IDLE) || (state == ST_DONE));
  // Acceptance uses the registered outstanding count, so a result can never
  // be matched against an issue happening in the same cycle.
  assign accept      = in_run && i_out_valid && (outstanding != '0);
  assign stray       = in_run && i_out_valid && (outstanding == '0);
  assign issue_next  = issue_cnt + CNT_W'(1);
  assign result_next = result_cnt + CNT_W'(1);
  assign timeout_next = {1'b0, timeout_cnt} + 9'd1;

  // Outstanding = issued - accepted; simultaneous issue and accept cancel.
  always_comb begin
    outstanding_next = outstanding;
    if (issuing && !accept)      outstanding_next = outstanding + CNT_W'(1);
    else if (!issuing && accept) outstanding_next = outstanding - CNT_W'(1);
  end

  // Sweep controller FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      n_latched   <= '0;
      issue_cnt   <= '0;
      result_cnt  <= '0;
      outstanding <= '0;
      timeout_cnt <= '0;
      o_x         <= '0;
      o_in_valid  <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            n_latched   <= i_count;
            issue_cnt   <= '0;
            result_cnt  <= '0;
            outstanding <= '0;
            timeout_cnt <= '0;
            o_error     <= 1'b0;
            if (i_count != '0) begin
              state      <= ST_ISSUE;
              o_x        <= X_START;
              o_in_valid <= 1'b1;
              o_busy     <= 1'b1;
              o_done     <= 1'b0;
            end else begin
              state      <= ST_DONE;
              o_in_valid <= 1'b0;
              o_busy     <= 1'b0;
              o_done     <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          issue_cnt   <= issue_next;
          outstanding <= outstanding_next;
          if (accept) result_cnt <= result_next;
          if (stray)  o_error    <= 1'b1;
          if (issue_next == n_latched) begin
            state       <= ST_DRAIN;
            o_in_valid  <= 1'b0;
            timeout_cnt <= '0;
          end else begin
            o_x <= o_x + X_W'(1);
          end
        end
        ST_DRAIN: begin
          outstanding <= outstanding_next;
          if (accept) result_cnt <= result_next;
          if (stray)  o_error    <= 1'b1;
          if (result_cnt == n_latched) begin
            state  <= ST_DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else if (accept) begin
            timeout_cnt <= '0;
          end else if (timeout_next >= TIMEOUT_L) begin
            o_error <= 1'b1;
            state   <= ST_DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end else begin
            timeout_cnt <= timeout_next[7:0];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sigmoid_sweep_collector_y_accum u_y_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_ok),
    .accept   (accept),
    .y        (i_y),
    .checksum (o_checksum),
    .max_y    (o_max_y),
    .number   (acc_number)
  );

  assign number = acc_number + reg_number(TOP_FLOPS)
                + NUM_W'(CNT_W) * (ADD_BIT_NUM + CMP_BIT_NUM) * 51'd4;

endmodule

// File: tb/tb_sigmoid_sweep_collector.sv
// Directed bench for sigmoid_sweep_collector with a latency-configurable
// responder standing in for the sigmoid unit (y = {8'h00, x}).
module tb_sigmoid_sweep_collector;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [8:0]  i_count;
  logic [7:0]  o_x;
  logic        o_in_valid;
  logic [15:0] i_y;
  logic        i_out_valid;
  logic        o_busy;
  logic        o_done;
  logic [23:0] o_checksum;
  logic [15:0] o_max_y;
  logic        o_error;
  logic [50:0] number;

  int total = 0;
  int bad   = 0;

  // Responder controls (written by the test tasks, read by the responder).
  int lat       = 2;
  int drop_abs  = -1;
  int extra_abs = -1;
  bit inject    = 1'b0;

  // Responder state (written only by the responder).
  int         emitted    = 0;
  bit         extra_next = 1'b0;
  logic       vpipe [0:7];
  logic [7:0] xpipe [0:7];

  sigmoid_sweep_collector dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (i_start),
    .i_count     (i_count),
    .o_x         (o_x),
    .o_in_valid  (o_in_valid),
    .i_y         (i_y),
    .i_out_valid (i_out_valid),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_checksum  (o_checksum),
    .o_max_y     (o_max_y),
    .o_error     (o_error),
    .number      (number)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sigmoid stand-in: captures issues at the falling edge and replays them
  // lat cycles later, with optional drop, trailing extra, or forced valids.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      for (int i = 0; i < 8; i++) begin
        vpipe[i] = 1'b0;
        xpipe[i] = 8'h00;
      end
      extra_next  = 1'b0;
      i_out_valid = 1'b0;
      i_y         = 16'h0000;
    end else begin
      for (int i = 7; i > 0; i--) begin
        vpipe[i] = vpipe[i-1];
        xpipe[i] = xpipe[i-1];
      end
      vpipe[0]    = o_in_valid;
      xpipe[0]    = o_x;
      i_out_valid = 1'b0;
      i_y         = 16'h0000;
      if (extra_next) begin
        i_out_valid = 1'b1;
        i_y         = 16'hABCD;
        extra_next  = 1'b0;
      end else if (inject) begin
        i_out_valid = 1'b1;
        i_y         = 16'hFFFF;
      end else if (vpipe[lat] === 1'b1) begin
        if (emitted != drop_abs) begin
          i_out_valid = 1'b1;
          i_y         = {8'h00, xpipe[lat]};
        end
        if (emitted == extra_abs) extra_next = 1'b1;
        emitted++;
      end
    end
  end

  // Pulse i_start for one cycle; returns at the falling edge of the first
  // cycle after the start edge.
  task automatic start_run(input logic [8:0] n);
    i_count = n;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (o_done !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_count = 9'd0;
    @(negedge clk);
    total++;
    if ({o_x, o_in_valid, o_busy, o_done, o_error} !== 12'h000) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got x=%h v=%b busy=%b done=%b err=%b expected all 0",
               o_x, o_in_valid, o_busy, o_done, o_error);
    end
    total++;
    if (o_checksum !== 24'h0 || o_max_y !== 16'h0) begin
      bad++;
      $display("[TB] FAIL reset_acc: got chk=%h max=%h expected 0/0", o_checksum, o_max_y);
    end
    total++;
    if ($isunknown(number) || number == 51'd0) begin
      bad++;
      $display("[TB] FAIL number_known: got %h expected known nonzero", number);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL idle_after_reset: got busy=%b done=%b expected 0/0", o_busy, o_done);
    end
  endtask

  task automatic test_sweep4;
    logic [7:0] exp_x;
    lat = 2;
    start_run(9'd4);
    for (int k = 0; k < 4; k++) begin
      exp_x = 8'(8'h80 + k);
      total++;
      if (o_in_valid !== 1'b1 || o_x !== exp_x || o_busy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL sweep4_issue%0d: got v=%b x=%h busy=%b expected 1/%h/1",
                 k, o_in_valid, o_x, o_busy, exp_x);
      end
      @(negedge clk);
    end
    total++;
    if (o_in_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sweep4_valid_drop: got %b expected 0", o_in_valid);
    end
    wait_done(50);
    total++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_checksum !== 24'h000206 ||
        o_max_y !== 16'h0083 || o_error !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sweep4_result: got done=%b busy=%b chk=%h max=%h err=%b expected 1/0/000206/0083/0",
               o_done, o_busy, o_checksum, o_max_y, o_error);
    end
    // Results arriving while DONE must be ignored without raising an error.
    inject = 1'b1;
    repeat (2) @(negedge clk);
    inject = 1'b0;
    @(negedge clk);
    total++;
    if (o_done !== 1'b1 || o_checksum !== 24'h000206 || o_max_y !== 16'h0083 || o_error !== 1'b0) begin
      bad++;
      $display("[TB] FAIL done_ignores_results: got done=%b chk=%h max=%h err=%b expected 1/000206/0083/0",
               o_done, o_checksum, o_max_y, o_error);
    end
  endtask

  task automatic test_sweep256;
    logic [7:0] exp_x;
    int         x_bad;
    lat   = 5;
    x_bad = 0;
    start_run(9'd256);
    for (int k = 0; k < 256; k++) begin
      exp_x = 8'(8'h80 + k);
      if (k == 50) begin
        i_start = 1'b1;
        i_count = 9'd1;
      end else begin
        i_start = 1'b0;
      end
      total++;
      if (o_in_valid !== 1'b1 || o_x !== exp_x) begin
        bad++;
        x_bad++;
        if (x_bad < 5)
          $display("[TB] FAIL sweep256_issue%0d: got v=%b x=%h expected 1/%h",
                   k, o_in_valid, o_x, exp_x);
      end
      @(negedge clk);
    end
    i_start = 1'b0;
    total++;
    if (o_in_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sweep256_valid_drop: got %b expected 0", o_in_valid);
    end
    wait_done(100);
    total++;
    if (o_done !== 1'b1 || o_checksum !== 24'h007F80 || o_max_y !== 16'h00FF || o_error !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sweep256_result: got done=%b chk=%h max=%h err=%b expected 1/007f80/00ff/0",
               o_done, o_checksum, o_max_y, o_error);
    end
  endtask

  task automatic test_timeout;
    lat      = 2;
    drop_abs = emitted + 2;
    start_run(9'd3);
    for (int k = 0; k < 3; k++) @(negedge clk);
    // Second result is accepted in this cycle; 15 empty DRAIN cycles follow.
    repeat (15) @(negedge clk);
    total++;
    if (o_done !== 1'b0 || o_busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL timeout_early: got done=%b busy=%b expected 0/1", o_done, o_busy);
    end
    @(negedge clk);
    total++;
    if (o_done !== 1'b1 || o_error !== 1'b1) begin
      bad++;
      $display("[TB] FAIL timeout_fire: got done=%b err=%b expected 1/1", o_done, o_error);
    end
    total++;
    if (o_checksum !== 24'h000101 || o_max_y !== 16'h0081) begin
      bad++;
      $display("[TB] FAIL timeout_partial: got chk=%h max=%h expected 000101/0081",
               o_checksum, o_max_y);
    end
    drop_abs = -1;
  endtask

  task automatic test_extra_result;
    lat       = 2;
    extra_abs = emitted + 1;
    start_run(9'd2);
    wait_done(50);
    total++;
    if (o_done !== 1'b1 || o_error !== 1'b1) begin
      bad++;
      $display("[TB] FAIL extra_error: got done=%b err=%b expected 1/1", o_done, o_error);
    end
    total++;
    if (o_checksum !== 24'h000101 || o_max_y !== 16'h0081) begin
      bad++;
      $display("[TB] FAIL extra_discarded: got chk=%h max=%h expected 000101/0081",
               o_checksum, o_max_y);
    end
    extra_abs = -1;
  endtask

  task automatic test_zero_count;
    int saw_valid;
    saw_valid = 0;
    start_run(9'd0);
    total++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_in_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL zero_done: got done=%b busy=%b v=%b expected 1/0/0",
               o_done, o_busy, o_in_valid);
    end
    total++;
    if (o_checksum !== 24'h0 || o_max_y !== 16'h0 || o_error !== 1'b0) begin
      bad++;
      $display("[TB] FAIL zero_cleared: got chk=%h max=%h err=%b expected 0/0/0",
               o_checksum, o_max_y, o_error);
    end
    for (int c = 0; c < 4; c++) begin
      if (o_in_valid !== 1'b0) saw_valid++;
      @(negedge clk);
    end
    total++;
    if (saw_valid != 0) begin
      bad++;
      $display("[TB] FAIL zero_no_issue: got %0d valid cycles expected 0", saw_valid);
    end
  endtask

  task automatic test_reset_midrun;
    lat = 2;
    start_run(9'd20);
    repeat (10) @(negedge clk);
    total++;
    if (o_x !== 8'h8A || o_in_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midrun_position: got x=%h v=%b expected 8a/1", o_x, o_in_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_x, o_in_valid, o_busy, o_done, o_error} !== 12'h000 ||
        o_checksum !== 24'h0 || o_max_y !== 16'h0) begin
      bad++;
      $display("[TB] FAIL midrun_reset: got x=%h v=%b busy=%b done=%b err=%b chk=%h max=%h expected all 0",
               o_x, o_in_valid, o_busy, o_done, o_error, o_checksum, o_max_y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_run(9'd1);
    total++;
    if (o_in_valid !== 1'b1 || o_x !== 8'h80) begin
      bad++;
      $display("[TB] FAIL restart_issue: got v=%b x=%h expected 1/80", o_in_valid, o_x);
    end
    @(negedge clk);
    total++;
    if (o_in_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL restart_single: got v=%b expected 0", o_in_valid);
    end
    wait_done(50);
    total++;
    if (o_done !== 1'b1 || o_checksum !== 24'h000080 || o_max_y !== 16'h0080 || o_error !== 1'b0) begin
      bad++;
      $display("[TB] FAIL restart_result: got done=%b chk=%h max=%h err=%b expected 1/000080/0080/0",
               o_done, o_checksum, o_max_y, o_error);
    end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_sweep4();
    test_sweep256();
    test_timeout();
    test_extra_result();
    test_zero_count();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so a stuck design cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
